// File: rtl/tlu_dut_responder.sv
// EUDET TLU DUT-side handshake: BUSY 4 CLK40 after trigger edge, serial trigger number read out, word held until DATA_READY.
// BUSY is held through readout and output backpressure. Define TLU_TIMESTAMP_EN to stamp DATA[30:16] with a 15-bit CLK40 counter.
module tlu_dut_responder #(
  parameter int TRIG_WIDTH = 15,
  parameter int CLK_DIV    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK40,
  input  logic        RESETB,
  input  logic        ENABLE,
  input  logic        TLU_TRIGGER,
  output logic        TLU_BUSY,
  output logic        TLU_CLOCK,
  output logic [31:0] DATA,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic [7:0]  ERR_CNT
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int BIT_W = 5;

  typedef enum logic [2:0] {IDLE, WAIT_LOW, SHIFT, OUTPUT, WAIT_IDLE} state_t;

  state_t             state, state_nxt;
  logic               trig_meta, trig_sync, trig_prev, trig_rise;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [15:0]        shreg;
  logic [14:0]        ts_lat;
  logic               div_end, last_bit, tmo_hit;

  assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(TRIG_WIDTH - 1));
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Two-flop synchronizer plus registered rising-edge detect
  always_ff @(posedge CLK40) begin
    if (!RESETB) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      trig_prev <= 1'b0;
      trig_rise <= 1'b0;
    end else begin
      trig_meta <= TLU_TRIGGER;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
      trig_rise <= trig_sync & ~trig_prev;
    end
  end

`ifdef TLU_TIMESTAMP_EN
  logic [14:0] ts;

  always_ff @(posedge CLK40) begin
    if (!RESETB) begin
      ts     <= '0;
      ts_lat <= '0;
    end else begin
      ts <= ts + 15'd1;
      if (state == IDLE && state_nxt == WAIT_LOW) ts_lat <= ts;
    end
  end
`else
  assign ts_lat = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (ENABLE && trig_rise) state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!trig_sync) state_nxt = SHIFT;
                 else if (tmo_hit) state_nxt = WAIT_IDLE;
      SHIFT:     if (div_end && !TLU_CLOCK && last_bit) state_nxt = OUTPUT;
      // DATA_VALID is high for the whole of OUTPUT
      OUTPUT:    if (DATA_READY) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!trig_sync) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (!RESETB) begin
      state      <= IDLE;
      TLU_BUSY   <= 1'b0;
      TLU_CLOCK  <= 1'b0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      ERR_CNT    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (state_nxt == WAIT_LOW) TLU_BUSY <= 1'b1;
        end
        WAIT_LOW: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          div_cnt <= '0;
          bit_cnt <= '0;
          shreg   <= '0;
          if (state_nxt == SHIFT) begin
            TLU_CLOCK <= 1'b1;
          end else if (state_nxt == WAIT_IDLE) begin
            TLU_BUSY <= 1'b0;
            if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (TLU_CLOCK) begin
              // Last high-phase cycle: the TLU bit has had time to pass the synchronizer
              shreg     <= {shreg[14:0], trig_sync};
              TLU_CLOCK <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (!last_bit) begin
                TLU_CLOCK <= 1'b1;
              end else begin
                DATA       <= {1'b1, ts_lat, shreg};
                DATA_VALID <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        OUTPUT: begin
          if (DATA_READY) begin
            DATA_VALID <= 1'b0;
            TLU_BUSY   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlu_dut_responder.sv
// Bench for tlu_dut_responder: TLU model drives trigger/number, scoreboard checks delivered words.
module tb_tlu_dut_responder;

  localparam int TW = 15;
  localparam int CD = 4;
  localparam int TO = 255;
  localparam logic [15:0] NUM_MASK = 16'((32'd1 << TW) - 1);
`ifdef TLU_TIMESTAMP_EN
  localparam logic [31:0] CMP_MASK = 32'h8000_FFFF;
`else
  localparam logic [31:0] CMP_MASK = 32'hFFFF_FFFF;
`endif

  logic        CLK40 = 1'b0;
  logic        RESETB = 1'b0;
  logic        ENABLE = 1'b0;
  logic        TLU_TRIGGER = 1'b0;
  logic        DATA_READY = 1'b1;
  logic        TLU_BUSY, TLU_CLOCK, DATA_VALID;
  logic [31:0] DATA;
  logic [7:0]  ERR_CNT;

  int checks = 0;
  int errors = 0;
  int words = 0;
  int rises = 0;
  int cyc = 0;
  int n_to = 0;
  logic clk_prev = 1'b0;
  logic [14:0] last_ts = '0;
  logic [31:0] sb[$];

  tlu_dut_responder #(.TRIG_WIDTH(TW), .CLK_DIV(CD), .TIMEOUT(TO)) dut (
    .CLK40(CLK40), .RESETB(RESETB), .ENABLE(ENABLE), .TLU_TRIGGER(TLU_TRIGGER),
    .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK), .DATA(DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK40 = ~CLK40;
  always @(posedge CLK40) cyc++;

  // Monitor: pulse counter and scoreboard, sampled mid-cycle
  always @(negedge CLK40) begin
    logic [31:0] exp;
    if (TLU_CLOCK && !clk_prev) rises++;
    clk_prev = TLU_CLOCK;
    if (RESETB && DATA_VALID && DATA_READY) begin
      words++;
      last_ts = DATA[30:16];
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %h want none", DATA);
      end else begin
        exp = sb.pop_front();
        if ((DATA & CMP_MASK) !== exp) begin
          errors++;
          $display("FAIL scoreboard_data got %h want %h", DATA & CMP_MASK, exp);
        end
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (TLU_BUSY !== 1'b0 && n < 400) begin step(); n++; end
    if (TLU_BUSY !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle got busy=%b want 0", TLU_BUSY);
    end
    steps(4);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (DATA_VALID !== 1'b1 && n < 200) begin step(); n++; end
    if (DATA_VALID !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_valid got valid=%b want 1", DATA_VALID);
    end
  endtask

  // TLU model: trigger, wait BUSY, then drive one bit per TLU_CLOCK rising edge, MSB first
  task automatic tlu_send(input logic [15:0] num, input bit accept, input int drop_en_bit);
    int lat, hi;
    if (accept) sb.push_back({1'b1, 15'd0, num & NUM_MASK});
    TLU_TRIGGER = 1'b1;
    lat = 0;
    while (TLU_BUSY !== 1'b1 && lat < 20) begin step(); lat++; end
    if (!accept) begin
      checks++;
      if (TLU_BUSY !== 1'b0) begin
        errors++;
        $display("FAIL busy_while_disabled got %b want 0", TLU_BUSY);
      end
      TLU_TRIGGER = 1'b0;
      steps(5);
      return;
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL busy_latency got %0d want 4", lat);
    end
    if (TLU_BUSY !== 1'b1) begin
      TLU_TRIGGER = 1'b0;
      return;
    end
    TLU_TRIGGER = 1'b0;
    for (int b = TW - 1; b >= 0; b--) begin
      lat = 0;
      while (TLU_CLOCK !== 1'b1 && lat < 64) begin step(); lat++; end
      if (TLU_CLOCK !== 1'b1) begin
        checks++; errors++;
        $display("FAIL tlu_clock_missing got bit %0d want rise", b);
        TLU_TRIGGER = 1'b0;
        return;
      end
      if (b != TW - 1) begin
        checks++;
        if (lat !== CD) begin
          errors++;
          $display("FAIL clock_low_width got %0d want %0d", lat, CD);
        end
      end
      if (b == drop_en_bit) ENABLE = 1'b0;
      TLU_TRIGGER = num[b];
      hi = 0;
      while (TLU_CLOCK === 1'b1 && hi < 64) begin step(); hi++; end
      checks++;
      if (hi !== CD) begin
        errors++;
        $display("FAIL clock_high_width got %0d want %0d", hi, CD);
      end
    end
    TLU_TRIGGER = 1'b0;
  endtask

  task automatic timeout_event(output bit ok);
    int n = 0;
    ok = 1'b0;
    TLU_TRIGGER = 1'b1;
    while (TLU_BUSY !== 1'b1 && n < 10) begin step(); n++; end
    n = 0;
    while (TLU_BUSY === 1'b1 && n < TO + 10) begin step(); n++; end
    TLU_TRIGGER = 1'b0;
    steps(4);
    if (n == TO) begin
      ok = 1'b1;
      n_to++;
    end
  endtask

  task automatic test_reset();
    RESETB = 1'b0;
    steps(3);
    checks++;
    if ({TLU_BUSY, TLU_CLOCK, DATA_VALID, DATA, ERR_CNT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b clk=%b vld=%b data=%h err=%0d want all 0",
               TLU_BUSY, TLU_CLOCK, DATA_VALID, DATA, ERR_CNT);
    end
    RESETB = 1'b1;
    ENABLE = 1'b1;
    steps(2);
  endtask

  task automatic test_basic();
    int w = words;
    int r = rises;
    tlu_send(16'h1234, 1'b1, -1);
    wait_valid();
    checks++;
    if (DATA[31] !== 1'b1 || DATA[15:0] !== 16'h1234 || TLU_CLOCK !== 1'b0) begin
      errors++;
      $display("FAIL basic_word got %h clk=%b want 1xxx1234 clk=0", DATA, TLU_CLOCK);
    end
    step();
    checks++;
    if (DATA_VALID !== 1'b0 || TLU_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got vld=%b busy=%b want 0 0", DATA_VALID, TLU_BUSY);
    end
    checks++;
    if (rises - r !== TW || words - w !== 1) begin
      errors++;
      $display("FAIL basic_pulses got %0d pulses %0d words want %0d 1", rises - r, words - w, TW);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int w = words;
    int unstable = 0;
    logic [31:0] held;
    DATA_READY = 1'b0;
    tlu_send(16'h00A5, 1'b1, -1);
    wait_valid();
    held = DATA;
    for (int i = 0; i < 100; i++) begin
      if (i == 30) TLU_TRIGGER = 1'b1;
      if (i == 40) TLU_TRIGGER = 1'b0;
      if (DATA !== held || DATA_VALID !== 1'b1 || TLU_BUSY !== 1'b1) unstable++;
      step();
    end
    checks++;
    if (unstable !== 0 || words !== w) begin
      errors++;
      $display("FAIL backpressure_hold got %0d unstable %0d words want 0 0", unstable, words - w);
    end
    DATA_READY = 1'b1;
    step();
    checks++;
    if (DATA_VALID !== 1'b0 || TLU_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got vld=%b busy=%b want 0 0", DATA_VALID, TLU_BUSY);
    end
    steps(20);
    checks++;
    if (words - w !== 1 || TLU_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_single got %0d words busy=%b want 1 0", words - w, TLU_BUSY);
    end
  endtask

  task automatic test_timeout();
    int w = words;
    int busy_cyc = 0;
    TLU_TRIGGER = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (TLU_BUSY === 1'b1) busy_cyc++;
    end
    TLU_TRIGGER = 1'b0;
    steps(5);
    n_to++;
    checks++;
    if (busy_cyc !== TO || ERR_CNT !== 8'd1 || words !== w) begin
      errors++;
      $display("FAIL timeout_first got busy=%0d err=%0d words=%0d want %0d 1 0",
               busy_cyc, ERR_CNT, words - w, TO);
    end
  endtask

  task automatic test_timestamp();
`ifdef TLU_TIMESTAMP_EN
    int c0;
    bit ok;
    logic [14:0] ts_a, diff;
    c0 = cyc;
    tlu_send(16'h0011, 1'b1, -1);
    wait_idle();
    ts_a = last_ts;
    while (cyc + 400 < c0 + 40000) begin
      timeout_event(ok);
      if (!ok) break;
    end
    while (cyc < c0 + 40000) step();
    tlu_send(16'h0022, 1'b1, -1);
    wait_idle();
    diff = last_ts - ts_a;
    checks++;
    if (diff !== 15'd7232) begin
      errors++;
      $display("FAIL timestamp_delta got %0d want 7232", diff);
    end
`else
    tlu_send(16'h0011, 1'b1, -1);
    wait_idle();
    checks++;
    if (last_ts !== 15'd0) begin
      errors++;
      $display("FAIL timestamp_zero got %0d want 0", last_ts);
    end
`endif
  endtask

  task automatic test_err_saturation();
    bit ok = 1'b1;
    while (n_to < 256 && ok) begin
      timeout_event(ok);
      if (n_to == 254) begin
        checks++;
        if (ERR_CNT !== 8'd254) begin
          errors++;
          $display("FAIL err_count_254 got %0d want 254", ERR_CNT);
        end
      end
    end
    checks++;
    if (!ok || ERR_CNT !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate got %0d events err=%0d want 256 255", n_to, ERR_CNT);
    end
  endtask

  task automatic test_enable();
    int w = words;
    ENABLE = 1'b0;
    tlu_send(16'h0FFF, 1'b0, -1);
    checks++;
    if (words !== w) begin
      errors++;
      $display("FAIL disabled_word got %0d words want 0", words - w);
    end
    ENABLE = 1'b1;
    steps(2);
    tlu_send(16'h0FFF, 1'b1, 7);
    wait_idle();
    checks++;
    if (words - w !== 1 || ENABLE !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop_word got %0d words want 1", words - w);
    end
    ENABLE = 1'b1;
  endtask

  task automatic test_back_to_back();
    int w = words;
    for (int i = 0; i < 6; i++) begin
      tlu_send(16'($urandom), 1'b1, -1);
      wait_idle();
      steps($urandom_range(0, 3));
    end
    checks++;
    if (words - w !== 6) begin
      errors++;
      $display("FAIL back_to_back_count got %0d want 6", words - w);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int r;
    int w = words;
    TLU_TRIGGER = 1'b1;
    while (TLU_BUSY !== 1'b1 && n < 20) begin step(); n++; end
    TLU_TRIGGER = 1'b0;
    r = rises;
    n = 0;
    // Eighth rising edge of TLU_CLOCK carries bit 7
    while (rises - r < 8 && n < 200) begin step(); n++; end
    RESETB = 1'b0;
    step();
    checks++;
    if ({TLU_BUSY, TLU_CLOCK, DATA_VALID, DATA, ERR_CNT} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b clk=%b vld=%b data=%h err=%0d want all 0",
               TLU_BUSY, TLU_CLOCK, DATA_VALID, DATA, ERR_CNT);
    end
    RESETB = 1'b1;
    n_to = 0;
    steps(3);
    tlu_send(16'h0001, 1'b1, -1);
    wait_idle();
    checks++;
    if (words - w !== 1) begin
      errors++;
      $display("FAIL reset_mid_next got %0d words want 1", words - w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_timestamp();
    test_err_saturation();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlu_dut_responder.md
TLU_DUT_RESPONDER -- requirements
Module: tlu_dut_responder

Interface
REQ-001 Parameter TRIG_WIDTH, default 15; number of trigger-number bits clocked out of the TLU, range 1-16.
REQ-002 Parameter CLK_DIV, default 4; TLU_CLOCK half-period in CLK40 cycles, minimum 4.
REQ-003 Parameter TIMEOUT, default 255; CLK40 cycles allowed for TLU_TRIGGER to fall after BUSY assertion.
REQ-004 CLK40  input  1  sole clock; all logic on rising edge.
REQ-005 RESETB  input  1  reset, synchronous, active-low.
REQ-006 ENABLE  input  1  accept new triggers when high.
REQ-007 TLU_TRIGGER  input  1  asynchronous TLU trigger / serial trigger-number line.
REQ-008 TLU_BUSY  output  1  handshake busy to TLU.
REQ-009 TLU_CLOCK  output  1  DUT-generated shift clock to TLU.
REQ-010 DATA  output  32  trigger word.
REQ-011 DATA_VALID  output  1  DATA holds an unread word.
REQ-012 DATA_READY  input  1  consumer accepts DATA.
REQ-013 ERR_CNT  output  8  saturating handshake-timeout counter.

Function
REQ-014 TLU_TRIGGER SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 States SHALL be IDLE, WAIT_LOW, SHIFT, OUTPUT, WAIT_IDLE.
REQ-016 IDLE: ENABLE=1 and synchronized-trigger rising edge -> WAIT_LOW; TLU_BUSY SHALL be registered high on the cycle after detection.
REQ-017 WAIT_LOW: trigger low -> SHIFT; TIMEOUT cycles elapsed with trigger still high -> ERR_CNT+1 (saturate at 255), TLU_BUSY low, -> WAIT_IDLE, no word produced.
REQ-018 SHIFT: TRIG_WIDTH TLU_CLOCK pulses, each CLK_DIV cycles high then CLK_DIV cycles low; TLU_CLOCK low at start and end of SHIFT.
REQ-019 Each bit SHALL be sampled from the synchronized trigger on the last high-phase cycle of its pulse; first bit = MSB.
REQ-020 After the last low phase -> OUTPUT; DATA = {1'b1, TS[14:0], number zero-extended to 16 bits}, DATA_VALID=1.
REQ-021 OUTPUT: DATA and DATA_VALID SHALL stay stable until a cycle with DATA_VALID=1 and DATA_READY=1; on that cycle -> WAIT_IDLE, and DATA_VALID and TLU_BUSY go low on the next cycle.
REQ-022 TLU_BUSY SHALL stay high from WAIT_LOW entry until the word is accepted; no trigger is lost or overwritten.
REQ-023 WAIT_IDLE: synchronized trigger low -> IDLE; a trigger held high SHALL NOT retrigger.
REQ-024 ENABLE deasserted mid-transaction: the transaction SHALL complete; the next trigger is ignored while ENABLE=0.
REQ-025 Trigger-to-BUSY latency SHALL be 4 CLK40 cycles: 2 synchronizer cycles, 1 edge-detect cycle, 1 output-register cycle.

Reset
REQ-026 RESETB=0 on a clock edge -> IDLE, TLU_BUSY=0, TLU_CLOCK=0, DATA=0, DATA_VALID=0, ERR_CNT=0, synchronizer=0, TS=0.
REQ-027 Reset mid-transaction SHALL abort it without emitting a word; the unread DATA word is discarded.

Configuration
REQ-028 Macro TLU_TIMESTAMP_EN defined: a free-running 15-bit CLK40 counter TS wraps at 32767; its value is latched on the IDLE->WAIT_LOW transition into DATA[30:16].
REQ-029 TLU_TIMESTAMP_EN undefined: no counter is built and DATA[30:16]=0.

Verification
REQ-030 TRIG_WIDTH=15, CLK_DIV=4, TLU model sends 0x1234, DATA_READY=1 -> DATA[15:0]=0x1234, DATA[31]=1, 15 TLU_CLOCK pulses of 8 cycles each, BUSY rises 4 cycles after trigger.
REQ-031 DATA_READY held 0 for 100 cycles, second TLU trigger pulse during that time -> DATA and BUSY stable, single word, second pulse ignored until WAIT_IDLE.
REQ-032 TLU_TRIGGER held high 300 cycles, TIMEOUT=255 -> ERR_CNT=1, no DATA_VALID; 256 such events -> ERR_CNT=255.
REQ-033 RESETB pulsed low during bit 7 of SHIFT -> all outputs 0 next cycle; next trigger 0x0001 decoded correctly.
REQ-034 TLU_TIMESTAMP_EN defined, triggers 40000 cycles apart -> DATA[30:16] difference = (40000 mod 32768); macro undefined -> DATA[30:16]=0.
REQ-035 ENABLE low with trigger 0x0FFF -> no BUSY, no word; ENABLE dropped during SHIFT -> word 0x0FFF still delivered.
